pwm_frame_sequencer: RTL and testbench

Frame timebase and command latch directly upstream of the four `pwm_generator_block` instances. Produces the shared `period_counter` and `high_counter` timebases and presents per-motor values that change only at frame boundaries, so no PWM pulse is ever truncated or stretched mid-frame. Accepts motor commands from the flight controller through a valid/ready handshake, clamps them to the legal pulse span, and forces zero throttle when disarmed or when commands stop arriving.

---
 rtl/pwm_frame_sequencer_pkg.sv | 12 +
 rtl/pwm_cmd_clamp.sv | 19 +
 rtl/pwm_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_pwm_frame_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_frame_sequencer_pkg.sv
// Shared PWM timing constants for the motor output path (all values in us).
package pwm_frame_sequencer_pkg;

   localparam int unsigned MIN_PWM_TIME_HIGH_US = 1000;
   localparam int unsigned MAX_PWM_TIME_HIGH_US = 2000;
   localparam int unsigned PWM_PERIOD_US        = 20000;
   localparam int unsigned PWM_SPAN_US          = MAX_PWM_TIME_HIGH_US - MIN_PWM_TIME_HIGH_US;
   localparam int unsigned PWM_TIMEOUT_FRAMES   = 25;

   localparam int NUM_MOTORS = 4;

endpackage

// File: rtl/pwm_cmd_clamp.sv
// Combinational clamp of one motor command to the legal pulse span.
module pwm_cmd_clamp
   import pwm_frame_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned SPAN  = PWM_SPAN_US
)(
   input  logic [WIDTH-1:0] cmd,
   output logic [WIDTH-1:0] clamped
);

   localparam logic [WIDTH-1:0] SPAN_W = WIDTH'(SPAN);

   // Requests above the span saturate at the span; everything else passes through.
   always_comb begin
      clamped = (cmd > SPAN_W) ? SPAN_W : cmd;
   end

endmodule

// File: rtl/pwm_frame_sequencer.sv
// Frame timebase and frame-aligned motor command latch feeding the PWM generators.
// Motor values only change on the edge that ends the last cycle of a frame.
module pwm_frame_sequencer
   import pwm_frame_sequencer_pkg::*;
#(
   parameter int unsigned INPUT_BIT_WIDTH = 10,
   parameter int unsigned TIMEOUT_FRAMES  = PWM_TIMEOUT_FRAMES,
   parameter int unsigned PERIOD_US       = PWM_PERIOD_US,
   parameter int unsigned MIN_HIGH_US     = MIN_PWM_TIME_HIGH_US,
   parameter int unsigned MAX_HIGH_US     = MAX_PWM_TIME_HIGH_US
)(
   input  logic                       us_clk,
   input  logic                       reset,
   input  logic                       armed,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [INPUT_BIT_WIDTH-1:0] cmd_motor1,
   input  logic [INPUT_BIT_WIDTH-1:0] cmd_motor2,
   input  logic [INPUT_BIT_WIDTH-1:0] cmd_motor3,
   input  logic [INPUT_BIT_WIDTH-1:0] cmd_motor4,
   output logic [15:0]                period_counter,
   output logic [INPUT_BIT_WIDTH-1:0] high_counter,
   output logic [INPUT_BIT_WIDTH-1:0] motor1_val,
   output logic [INPUT_BIT_WIDTH-1:0] motor2_val,
   output logic [INPUT_BIT_WIDTH-1:0] motor3_val,
   output logic [INPUT_BIT_WIDTH-1:0] motor4_val,
   output logic                       frame_start,
   output logic                       failsafe
);

   localparam int unsigned W          = INPUT_BIT_WIDTH;
   localparam int unsigned SPAN       = MAX_HIGH_US - MIN_HIGH_US;
   localparam int unsigned MISS_W     = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [15:0] PERIOD_END = 16'(PERIOD_US);
   localparam logic [15:0] HIGH_START = 16'(MIN_HIGH_US);
   localparam logic [W-1:0] HIGH_MAX  = '1;
   localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(TIMEOUT_FRAMES);

   logic              running;      // low only in the first cycle after reset
   logic              accept;
   logic              boundary;
   logic              failsafe_next;
   logic [MISS_W-1:0] miss_cnt;
   logic [MISS_W-1:0] miss_next;
   logic [W-1:0]      cmd_raw     [NUM_MOTORS];
   logic [W-1:0]      cmd_clamped [NUM_MOTORS];
   logic [W-1:0]      shadow      [NUM_MOTORS];
   logic [W-1:0]      motor       [NUM_MOTORS];

   assign cmd_raw[0] = cmd_motor1;
   assign cmd_raw[1] = cmd_motor2;
   assign cmd_raw[2] = cmd_motor3;
   assign cmd_raw[3] = cmd_motor4;

   for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_clamp
      pwm_cmd_clamp #(.WIDTH(W), .SPAN(SPAN)) u_clamp (
         .cmd     (cmd_raw[i]),
         .clamped (cmd_clamped[i])
      );
   end

   assign cmd_ready  = ~reset;
   assign failsafe   = (miss_cnt == MISS_LIMIT);
   assign motor1_val = motor[0];
   assign motor2_val = motor[1];
   assign motor3_val = motor[2];
   assign motor4_val = motor[3];

   // Handshake, frame boundary and the miss count this edge will produce.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      accept    = cmd_valid & ~reset;
      boundary  = (period_counter == PERIOD_END);
      miss_next = miss_cnt;
      if (accept) begin
         miss_next = '0;
      end else if (boundary && (miss_cnt != MISS_LIMIT)) begin
         miss_next = miss_cnt + MISS_W'(1);
      end
      failsafe_next = (miss_next == MISS_LIMIT);
   end

   // Frame timebase: hold 0 for one cycle after reset, then count 0..PERIOD_US and wrap.
   always_ff @(posedge us_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         running        <= 1'b0;
         period_counter <= '0;
         high_counter   <= '0;
         frame_start    <= 1'b0;
      end else begin
         running <= 1'b1;
         if (!running || boundary) begin
            period_counter <= '0;
            frame_start    <= 1'b1;
         end else begin
            period_counter <= period_counter + 16'd1;
            frame_start    <= 1'b0;
         end
         if (!running || boundary || (period_counter < HIGH_START)) begin
            high_counter <= '0;
         end else if (high_counter != HIGH_MAX) begin
            high_counter <= high_counter + W'(1);
         end
      end
   end

   // Consecutive-frame miss counter; failsafe is its saturated state.
   always_ff @(posedge us_clk) begin
      if (reset) begin
         miss_cnt <= MISS_LIMIT;
      end else begin
         miss_cnt <= miss_next;
      end
   end

   // Shadow registers capture the latest clamped command.
   always_ff @(posedge us_clk) begin
      // NOTE: these per-motor arrays are ordinary flops, not a RAM, so each entry is reset explicitly.
      if (reset) begin
         for (int i = 0; i < NUM_MOTORS; i++) shadow[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_MOTORS; i++) shadow[i] <= cmd_clamped[i];
      end
   end

   // Active motor values load only at the frame boundary; a same-cycle command bypasses the shadow.
   always_ff @(posedge us_clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_MOTORS; i++) motor[i] <= '0;
      end else if (boundary) begin
         for (int i = 0; i < NUM_MOTORS; i++) begin
            if (!armed || failsafe_next) begin
               motor[i] <= '0;
            end else if (accept) begin
               motor[i] <= cmd_clamped[i];
            end else begin
               motor[i] <= shadow[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Randomized bench for pwm_frame_sequencer with a frame-level reference model.
// Uses a shortened frame so failsafe, saturation and recovery fit in a short run.
module tb_pwm_frame_sequencer;

   localparam int W    = 7;
   localparam int T    = 3;
   localparam int P    = 199;
   localparam int MIN  = 50;
   localparam int MAX  = 100;
   localparam int SPAN = MAX - MIN;
   localparam int HMAX = (1 << W) - 1;

   logic         us_clk = 1'b0;
   logic         reset  = 1'b1;
   logic         armed  = 1'b0;
   logic         cmd_valid = 1'b0;
   logic [W-1:0] cmd_in [4];
   logic         cmd_ready;
   logic [15:0]  period_counter;
   logic [W-1:0] high_counter;
   logic [W-1:0] motor1_val, motor2_val, motor3_val, motor4_val;
   logic         frame_start;
   logic         failsafe;

   always #1 us_clk = ~us_clk;

   pwm_frame_sequencer #(
      .INPUT_BIT_WIDTH (W),
      .TIMEOUT_FRAMES  (T),
      .PERIOD_US       (P),
      .MIN_HIGH_US     (MIN),
      .MAX_HIGH_US     (MAX)
   ) dut (
      .us_clk         (us_clk),
      .reset          (reset),
      .armed          (armed),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_motor1     (cmd_in[0]),
      .cmd_motor2     (cmd_in[1]),
      .cmd_motor3     (cmd_in[2]),
      .cmd_motor4     (cmd_in[3]),
      .period_counter (period_counter),
      .high_counter   (high_counter),
      .motor1_val     (motor1_val),
      .motor2_val     (motor2_val),
      .motor3_val     (motor3_val),
      .motor4_val     (motor4_val),
      .frame_start    (frame_start),
      .failsafe       (failsafe)
   );

   // Reference model: t = clock edges since reset released, last accepted command,
   // frames since that command, and the values presented this frame.
   int t;
   int miss_m;
   int shadow_m [4];
   int motor_m  [4];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic int clampv(input int x);
      return (x > SPAN) ? SPAN : x;
   endfunction

   function automatic int exp_pc();
      return (t == 0) ? 0 : (t - 1) % (P + 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0d: got %0d, expected %0d", tag, t, got, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs now being driven.
   task automatic model_edge();
      bit bnd;
      if (reset) begin
         t      = 0;
         miss_m = T;
         for (int i = 0; i < 4; i++) begin
            shadow_m[i] = 0;
            motor_m[i]  = 0;
         end
      end else begin
         bnd = (t > 0) && (exp_pc() == P);
         if (cmd_valid) begin
            for (int i = 0; i < 4; i++) shadow_m[i] = clampv(int'(cmd_in[i]));
            miss_m = 0;
         end else if (bnd && miss_m < T) begin
            miss_m++;
         end
         if (bnd) begin
            for (int i = 0; i < 4; i++) motor_m[i] = (!armed || miss_m == T) ? 0 : shadow_m[i];
         end
         t++;
      end
   endtask

   task automatic compare();
      int pc;
      int hi;
      pc = exp_pc();
      hi = (pc <= MIN) ? 0 : ((pc - MIN > HMAX) ? HMAX : pc - MIN);
      check("period_counter", 32'(period_counter), 32'(pc));
      check("high_counter",   32'(high_counter),   32'(hi));
      check("frame_start",    32'(frame_start),    32'((t > 0) && (pc == 0)));
      check("cmd_ready",      32'(cmd_ready),      32'(!reset));
      check("failsafe",       32'(failsafe),       32'(miss_m == T));
      check("motor1_val",     32'(motor1_val),     32'(motor_m[0]));
      check("motor2_val",     32'(motor2_val),     32'(motor_m[1]));
      check("motor3_val",     32'(motor3_val),     32'(motor_m[2]));
      check("motor4_val",     32'(motor4_val),     32'(motor_m[3]));
   endtask

   task automatic tick();
      model_edge();
      @(negedge us_clk);
      compare();
   endtask

   // Advance at least one cycle, then until the model frame position equals target.
   task automatic run_to(input int target);
      tick();
      for (int i = 0; i < 2 * (P + 1) && exp_pc() != target; i++) tick();
   endtask

   task automatic set_cmd(input int a, input int b, input int c, input int d);
      cmd_in[0] = W'(a);
      cmd_in[1] = W'(b);
      cmd_in[2] = W'(c);
      cmd_in[3] = W'(d);
   endtask

   task automatic pulse_cmd(input int a, input int b, input int c, input int d);
      set_cmd(a, b, c, d);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int rate;
      set_cmd(0, 0, 0, 0);

      // Reset held, then free-run through two full frames with no commands.
      repeat (3) tick();
      reset = 1'b0;
      repeat (2 * (P + 1) + 5) tick();

      // Armed command mid-frame, including values at and beyond the span.
      armed = 1'b1;
      run_to(80);
      pulse_cmd(30, 0, SPAN, HMAX);
      run_to(5);

      // Command accepted on the boundary cycle itself.
      run_to(P);
      pulse_cmd(11, 22, 33, 44);
      run_to(3);

      // Two commands in one frame: only the later one is presented.
      run_to(40);
      pulse_cmd(1, 2, 3, 4);
      run_to(120);
      pulse_cmd(49, 51, 7, 100);
      run_to(2);

      // Silence until failsafe engages, then recover with a fresh command.
      repeat ((T + 1) * (P + 1)) tick();
      run_to(90);
      pulse_cmd(17, 18, 19, 20);
      run_to(2);

      // Disarmed with commands flowing, then re-armed.
      armed = 1'b0;
      for (int i = 0; i < 2 * (P + 1); i++) begin
         if (i % 10 == 0) begin
            set_cmd($urandom_range(0, HMAX), $urandom_range(0, HMAX),
                    $urandom_range(0, HMAX), $urandom_range(0, HMAX));
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         tick();
      end
      cmd_valid = 1'b0;
      armed     = 1'b1;
      repeat (P + P / 2) tick();

      // Reset pulsed mid-frame, after the high window has opened.
      run_to(150);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (P + 10) tick();

      // Random traffic: per-frame command rate, rare arming changes and rare resets.
      rate = 4;
      for (int c = 0; c < 60 * (P + 1); c++) begin
         if (exp_pc() == 0) begin
            case ($urandom_range(0, 3))
               0:       rate = 4;
               1:       rate = 150;
               2:       rate = 400;
               default: rate = 100000;
            endcase
         end
         set_cmd($urandom_range(0, HMAX), $urandom_range(0, HMAX),
                 $urandom_range(0, HMAX), $urandom_range(0, HMAX));
         cmd_valid = ($urandom_range(0, rate) == 0);
         if ($urandom_range(0, 499) == 0) armed = ~armed;
         reset = ($urandom_range(0, 3999) == 0);
         tick();
      end
      reset     = 1'b0;
      cmd_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
